// File: rtl/jtframe_pocket_pkg.sv
`default_nettype none
// ============================================================================
// Package : jtframe_pocket_pkg
// Desc    : Shared types and constants for the Pocket bridge helper blocks.
// Rev     : 1.0  initial release
// ============================================================================
package jtframe_pocket_pkg;

    localparam logic [31:0] POCKET_NVRAM_WIN = 32'h6000_0000;
    localparam int          IOCTL_AW         = 25;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ISSUE = 3'd1,
        WAIT  = 3'd2,
        STORE = 3'd3,
        DONE  = 3'd4
    } nvram_rd_st_t;

endpackage
`default_nettype wire

// File: rtl/jtframe_pocket_nvram_rd.sv
`default_nettype none
// ============================================================================
// Module : jtframe_pocket_nvram_rd
// Desc   : Bridge host read-back of core memory: fetches four bytes through a
//          byte-wide memory port and returns them as one 32-bit word.
// Rev    : 1.0  initial release
// ============================================================================
module jtframe_pocket_nvram_rd
    import jtframe_pocket_pkg::*;
#(
    parameter logic [31:0]         WIN_BASE = POCKET_NVRAM_WIN,
    parameter int                  AW       = 16,
    parameter logic [IOCTL_AW-1:0] MEM_BASE = '0,
    parameter int                  LAT      = 2,
    parameter bit                  BIG_END  = 1'b1
)(
    input  logic                clk_sys,
    input  logic                rst_n,
    input  logic                rd_req,
    input  logic [31:0]         rd_addr,
    output logic [31:0]         rd_data,
    output logic                rd_ok,
    output logic                busy,
    output logic [IOCTL_AW-1:0] mem_addr,
    output logic                mem_rd,
    input  logic [7:0]          mem_din,
    output logic                overrun,
    input  logic                ovr_clr
);

    localparam logic [2:0] c_cnt_load = 3'(LAT - 1);

    nvram_rd_st_t        r_st;
    nvram_rd_st_t        w_st_nxt;
    logic [1:0]          r_k;
    logic [2:0]          r_cnt;
    logic [31:0]         r_asm;
    logic                w_hit;
    logic                w_accept;
    logic                w_miss;
    logic                w_store;
    logic                w_done;
    logic [1:0]          w_lane;
    logic [IOCTL_AW-1:0] w_first;
    logic                w_unused;

    assign w_hit    = rd_addr[31:AW] == WIN_BASE[31:AW];
    assign w_first  = MEM_BASE + IOCTL_AW'({rd_addr[AW-1:2], 2'b00});
    assign w_lane   = BIG_END ? 2'd3 - r_k : r_k;
    assign w_unused = ^rd_addr[1:0];

    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) r_st <= IDLE;
        else        r_st <= w_st_nxt;
    end

    always_comb begin
        w_st_nxt = r_st;
        w_accept = 1'b0;
        w_miss   = 1'b0;
        w_store  = 1'b0;
        w_done   = 1'b0;
        case (r_st)
            IDLE: begin
                // busy is still high during the rd_ok cycle, so requests there are dropped
                if (rd_req && !busy) begin
                    if (w_hit) begin
                        w_accept = 1'b1;
                        w_st_nxt = ISSUE;
                    end else begin
                        w_miss = 1'b1;
                    end
                end
            end
            ISSUE:   w_st_nxt = (LAT == 1) ? STORE : WAIT;
            WAIT:    if (r_cnt == 3'd1) w_st_nxt = STORE;
            STORE: begin
                w_store  = 1'b1;
                w_st_nxt = (r_k == 2'd3) ? DONE : ISSUE;
            end
            DONE: begin
                w_done   = 1'b1;
                w_st_nxt = IDLE;
            end
            default: w_st_nxt = IDLE;
        endcase
    end

    // mem_addr is loaded on entry to ISSUE so the byte address is already
    // on the port during ISSUE, giving exactly LAT cycles until STORE samples.
    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            rd_data  <= '0;
            rd_ok    <= 1'b0;
            busy     <= 1'b0;
            mem_addr <= '0;
            mem_rd   <= 1'b0;
            overrun  <= 1'b0;
            r_k      <= '0;
            r_cnt    <= '0;
            r_asm    <= '0;
        end else begin
            rd_ok <= 1'b0;
            if (rd_ok) busy <= 1'b0;
            if (w_accept) begin
                busy     <= 1'b1;
                mem_rd   <= 1'b1;
                mem_addr <= w_first;
                r_k      <= 2'd0;
            end
            if (w_miss) begin
                busy    <= 1'b1;
                rd_ok   <= 1'b1;
                rd_data <= '0;
            end
            if (r_st == ISSUE)     r_cnt <= c_cnt_load;
            else if (r_st == WAIT) r_cnt <= r_cnt - 3'd1;
            if (w_store) begin
                r_asm[{w_lane, 3'b000} +: 8] <= mem_din;
                if (r_k == 2'd3) begin
                    mem_rd <= 1'b0;
                end else begin
                    r_k      <= r_k + 2'd1;
                    mem_addr <= mem_addr + IOCTL_AW'(1);
                end
            end
            if (w_done) begin
                rd_data <= r_asm;
                rd_ok   <= 1'b1;
            end
            if (rd_req && busy) overrun <= 1'b1;
            else if (ovr_clr)   overrun <= 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_jtframe_pocket_nvram_rd.sv
`default_nettype none
// ============================================================================
// Module : tb_jtframe_pocket_nvram_rd
// Desc   : Scoreboard bench for the NVRAM read-back block; dut0 is LAT=2 big
//          endian, dut1 is LAT=1 little endian.
// Rev    : 1.0  initial release
// ============================================================================
module tb_jtframe_pocket_nvram_rd;

    typedef struct {
        logic [31:0] data;
        int          req_cyc;
        int          lat;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic        rst_n    [2];
    logic        rd_req   [2];
    logic        ovr_clr  [2];
    logic        rd_ok    [2];
    logic        busy     [2];
    logic        mem_rd   [2];
    logic        overrun  [2];
    logic [31:0] rd_addr  [2];
    logic [31:0] rd_data  [2];
    logic [24:0] mem_addr [2];
    logic [7:0]  mem_din  [2];
    logic [7:0]  mem      [65536];

    int          n_checks = 0;
    int          n_fail   = 0;
    exp_t        q0[$];
    exp_t        q1[$];
    logic [24:0] a0[$];
    logic [24:0] a1[$];
    logic [31:0] last_data [2] = '{32'd0, 32'd0};
    logic        prev_rd   [2] = '{1'b0, 1'b0};
    logic [24:0] prev_addr [2];

    for (genvar g = 0; g < 2; g++) begin : g_dut
        localparam int L = (g == 0) ? 2 : 1;
        logic [7:0] pipe [2];
        always @(posedge clk) begin
            pipe[0] <= mem[mem_addr[g][15:0]];
            pipe[1] <= pipe[0];
        end
        assign mem_din[g] = pipe[L-1];

        jtframe_pocket_nvram_rd #(
            .WIN_BASE (32'h6000_0000),
            .AW       (16),
            .MEM_BASE (25'h0),
            .LAT      (L),
            .BIG_END  (g == 0)
        ) u_dut (
            .clk_sys  (clk),
            .rst_n    (rst_n[g]),
            .rd_req   (rd_req[g]),
            .rd_addr  (rd_addr[g]),
            .rd_data  (rd_data[g]),
            .rd_ok    (rd_ok[g]),
            .busy     (busy[g]),
            .mem_addr (mem_addr[g]),
            .mem_rd   (mem_rd[g]),
            .mem_din  (mem_din[g]),
            .overrun  (overrun[g]),
            .ovr_clr  (ovr_clr[g])
        );
    end

    function automatic int lat_of(input int i);
        return (i == 0) ? 2 : 1;
    endfunction

    function automatic void chk(input string name, input int i, input logic [31:0] act, input logic [31:0] want);
        n_checks++;
        if (act !== want) begin
            n_fail++;
            $display("FAIL %s dut%0d: got %h, required %h", name, i, act, want);
        end
    endfunction

    function automatic void fail_now(input string name, input int i, input int act);
        n_checks++;
        n_fail++;
        $display("FAIL %s dut%0d: got %0d, required 0", name, i, act);
    endfunction

    function automatic int qsize(input int i);
        return (i == 0) ? q0.size() : q1.size();
    endfunction

    function automatic int asize(input int i);
        return (i == 0) ? a0.size() : a1.size();
    endfunction

    function automatic exp_t qpop(input int i);
        if (i == 0) return q0.pop_front();
        return q1.pop_front();
    endfunction

    function automatic logic [24:0] apop(input int i);
        if (i == 0) return a0.pop_front();
        return a1.pop_front();
    endfunction

    function automatic void flush(input int i);
        if (i == 0) begin q0.delete(); a0.delete(); end
        else        begin q1.delete(); a1.delete(); end
    endfunction

    // Reference: a hit returns the four bytes of the aligned word at
    // window offset, packed by endianness; a miss returns zero at once.
    task automatic req(input int i, input logic [31:0] a);
        exp_t        e;
        logic [24:0] base;
        logic [7:0]  b [4];
        e.req_cyc = cyc + 1;
        base = {9'd0, a[15:2], 2'b00};
        for (int k = 0; k < 4; k++) b[k] = mem[base[15:0] + 16'(k)];
        if (a[31:16] != 16'h6000) begin
            e.data = 32'd0;
            e.lat  = 0;
        end else begin
            e.data = (i == 0) ? {b[0], b[1], b[2], b[3]} : {b[3], b[2], b[1], b[0]};
            e.lat  = 4 * (lat_of(i) + 1) + 1;
            for (int k = 0; k < 4; k++) begin
                if (i == 0) a0.push_back(base + 25'(k));
                else        a1.push_back(base + 25'(k));
            end
        end
        if (i == 0) q0.push_back(e);
        else        q1.push_back(e);
        rd_req[i]  = 1'b1;
        rd_addr[i] = a;
        @(negedge clk);
        rd_req[i]  = 1'b0;
    endtask

    task automatic wait_idle(input int i);
        int n = 0;
        while (qsize(i) != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (qsize(i) != 0) begin
            fail_now("response_timeout", i, qsize(i));
            flush(i);
        end
        @(negedge clk);
    endtask

    task automatic mon(input int i);
        exp_t e;
        if (!rst_n[i]) begin
            last_data[i] = 32'd0;
            prev_rd[i]   = 1'b0;
            return;
        end
        if (mem_rd[i] && (!prev_rd[i] || mem_addr[i] != prev_addr[i])) begin
            if (asize(i) == 0) fail_now("unexpected_mem_read", i, 1);
            else chk("mem_addr", i, 32'(mem_addr[i]), 32'(apop(i)));
        end
        prev_rd[i]   = mem_rd[i];
        prev_addr[i] = mem_addr[i];
        if (rd_ok[i]) begin
            if (qsize(i) == 0) begin
                fail_now("unexpected_rd_ok", i, 1);
            end else begin
                e = qpop(i);
                chk("rd_data", i, rd_data[i], e.data);
                chk("latency", i, 32'(cyc - e.req_cyc), 32'(e.lat));
                chk("busy_at_rd_ok", i, 32'(busy[i]), 32'd1);
            end
            last_data[i] = rd_data[i];
        end else begin
            chk("rd_data_hold", i, rd_data[i], last_data[i]);
        end
    endtask

    always @(posedge clk) begin
        #1;
        for (int i = 0; i < 2; i++) mon(i);
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation still running, required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int          n;
        logic [31:0] a;
        for (int i = 0; i < 2; i++) begin
            rst_n[i]   = 1'b0;
            rd_req[i]  = 1'b0;
            ovr_clr[i] = 1'b0;
            rd_addr[i] = 32'd0;
        end
        for (int j = 0; j < 65536; j++) mem[j] = 8'($urandom);
        mem[16'h0100] = 8'h11;
        mem[16'h0101] = 8'h22;
        mem[16'h0102] = 8'h33;
        mem[16'h0103] = 8'h44;

        repeat (2) @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            chk("reset_rd_data",  i, rd_data[i], 32'd0);
            chk("reset_rd_ok",    i, 32'(rd_ok[i]), 32'd0);
            chk("reset_busy",     i, 32'(busy[i]), 32'd0);
            chk("reset_mem_addr", i, 32'(mem_addr[i]), 32'd0);
            chk("reset_mem_rd",   i, 32'(mem_rd[i]), 32'd0);
            chk("reset_overrun",  i, 32'(overrun[i]), 32'd0);
        end
        rst_n[0] = 1'b1;
        rst_n[1] = 1'b1;
        @(negedge clk);

        // dut0: basic big-endian read
        req(0, 32'h6000_0102);
        wait_idle(0);
        chk("basic_word", 0, rd_data[0], 32'h1122_3344);

        // dut0: overrun while busy, then set-wins and clear
        chk("overrun_before", 0, 32'(overrun[0]), 32'd0);
        req(0, 32'h6000_0100);
        repeat (4) @(negedge clk);
        rd_req[0]  = 1'b1;
        rd_addr[0] = 32'h6000_0200;
        @(negedge clk);
        rd_req[0]  = 1'b0;
        chk("overrun_set", 0, 32'(overrun[0]), 32'd1);
        wait_idle(0);
        chk("overrun_first_word", 0, rd_data[0], 32'h1122_3344);
        req(0, 32'h6000_0300);
        @(negedge clk);
        rd_req[0]  = 1'b1;
        ovr_clr[0] = 1'b1;
        @(negedge clk);
        rd_req[0]  = 1'b0;
        ovr_clr[0] = 1'b0;
        chk("overrun_set_wins", 0, 32'(overrun[0]), 32'd1);
        ovr_clr[0] = 1'b1;
        @(negedge clk);
        ovr_clr[0] = 1'b0;
        chk("overrun_clear", 0, 32'(overrun[0]), 32'd0);
        wait_idle(0);

        // dut0: randomized hits and misses
        for (int t = 0; t < 16; t++) begin
            a = $urandom;
            if ($urandom_range(0, 3) == 0) a[31:16] = 16'h6000 ^ 16'($urandom_range(1, 65535));
            else                           a[31:16] = 16'h6000;
            req(0, a);
            wait_idle(0);
        end
        chk("overrun_after_random", 0, 32'(overrun[0]), 32'd0);

        // dut0: reset during byte 2, then last word of the window
        req(0, 32'h6000_0200);
        n = 0;
        while (!(mem_rd[0] && mem_addr[0] == 25'h202) && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) fail_now("byte2_timeout", 0, n);
        rst_n[0] = 1'b0;
        #1;
        chk("abort_mem_rd", 0, 32'(mem_rd[0]), 32'd0);
        chk("abort_busy",   0, 32'(busy[0]), 32'd0);
        flush(0);
        repeat (2) @(negedge clk);
        rst_n[0] = 1'b1;
        @(negedge clk);
        req(0, 32'h6000_FFFC);
        wait_idle(0);

        // dut1: little endian, word held until next completion
        req(1, 32'h6000_0040);
        wait_idle(1);
        req(1, 32'h6000_0102);
        wait_idle(1);
        chk("le_word", 1, rd_data[1], 32'h4433_2211);

        // dut1: window miss
        req(1, 32'h7000_0000);
        wait_idle(1);
        chk("miss_word", 1, rd_data[1], 32'd0);

        // dut1: LAT=1 back-to-back sweep
        for (int t = 0; t < 10; t++) begin
            a = {16'h6000, 16'($urandom)};
            req(1, a);
            wait_idle(1);
        end
        chk("sweep_overrun", 1, 32'(overrun[1]), 32'd0);

        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/jtframe_pocket_nvram_rd.md
Name: jtframe_pocket_nvram_rd

Overview:
- Read-back path for Pocket bridge host reads of core memory, such as NVRAM or hiscore save. It is the reverse of the bridge-to-ioctl write download.
- Accepts 32-bit word read requests from the bridge responder and fetches four bytes through the byte-wide ioctl_din-style memory port.
- Assembles those bytes into a 32-bit word and returns it with a completion strobe.
- Sits between the pocket base bridge decoder and the game's NVRAM port.

Parameters:
- WIN_BASE, 32'h6000_0000: bridge address of the window start. It must be aligned to 2**AW.
- AW, 16: log2 of the window size in bytes; valid range 2..24.
- MEM_BASE, 25'h0: memory-port address that corresponds to window offset 0.
- LAT, 2: memory-port read latency in cycles from mem_addr valid to mem_din valid; valid range 1..7.
- BIG_END, 1'b1: 1 places byte 0 in rd_data[31:24]; 0 places byte 0 in rd_data[7:0].

Ports:
- clk_sys  in  1  system clock; all logic is on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- rd_req  in  1  single-cycle read request from the bridge responder.
- rd_addr  in  32  bridge byte address; sampled only when rd_req=1; bits [1:0] are ignored.
- rd_data  out  32  assembled word; held stable until the next completion.
- rd_ok  out  1  single-cycle strobe; rd_data is valid in the same cycle.
- busy  out  1  high from the cycle after an accepted rd_req until the rd_ok cycle, inclusive.
- mem_addr  out  25  byte address to the memory port.
- mem_rd  out  1  memory read enable; high while a byte access is in flight.
- mem_din  in  8  byte returned by the memory port.
- overrun  out  1  sticky flag: an rd_req arrived while busy=1.
- ovr_clr  in  1  clears overrun.

Behaviour:
- Reset values: rd_data=0, rd_ok=0, busy=0, mem_addr=0, mem_rd=0, overrun=0, FSM=IDLE.
- Reset is async. Asserting it mid-transfer aborts immediately: mem_rd drops at once and no rd_ok is issued.
- Window hit condition: rd_addr[31:AW] == WIN_BASE[31:AW].
- Word offset: off = {rd_addr[AW-1:2], 2'b00}. Byte k address = MEM_BASE + off + k, computed 25-bit and truncated on overflow.
- FSM states: IDLE, ISSUE, WAIT, STORE, DONE.
  - IDLE, rd_req with a hit: latch off, set k=0, busy=1, go to ISSUE.
  - IDLE, rd_req with a miss: next cycle rd_data=0 and rd_ok=1. There is no memory access. busy is high only in that rd_ok cycle.
  - ISSUE: drive mem_addr for byte k, set mem_rd=1, load the wait counter to LAT-1, go to WAIT. Skip WAIT when LAT=1.
  - WAIT: decrement the counter; at 0 go to STORE.
  - STORE: capture mem_din into byte lane k. If k<3, increment k and go to ISSUE; otherwise go to DONE. mem_rd stays high across bytes and mem_addr stays stable during each byte.
  - DONE: mem_rd=0, update rd_data from the assembly register, rd_ok=1, busy=0 on the next cycle, return to IDLE.
- Timing: mem_din is sampled exactly LAT cycles after the cycle in which that byte's mem_addr first appears.
- Hit latency: rd_ok occurs 4*(LAT+1)+1 cycles after the rd_req sample edge. For LAT=2 that is 13 cycles.
- A partial assembly is never visible on rd_data.
- Byte lanes:
  - BIG_END=1: byte0→[31:24], byte1→[23:16], byte2→[15:8], byte3→[7:0].
  - BIG_END=0: the mirror arrangement.
- Overrun:
  - rd_req while busy=1 (including the rd_ok cycle) is dropped and sets overrun.
  - ovr_clr in the same cycle as a new overrun event: set wins.
  - ovr_clr alone clears overrun on the next edge.
- An rd_req arriving in the cycle after rd_ok (FSM back in IDLE) is accepted normally.
- Last word of the window (off = 2**AW-4) is read with no special handling.

Decomposition:
- Shared package jtframe_pocket_pkg holds:
  - FSM state enum nvram_rd_st_t (IDLE/ISSUE/WAIT/STORE/DONE);
  - localparam POCKET_NVRAM_WIN default;
  - 25-bit ioctl address width constant IOCTL_AW.
- No sub-module is needed. Byte-lane assembly is an indexed write inside the FSM.

Test Plan:
- Basic read: LAT=2, BIG_END=1, memory model bytes 0x100..0x103 = 11,22,33,44; rd_req with rd_addr=0x6000_0102 → mem_addr 0x100..0x103 in order; rd_ok 13 cycles later; rd_data=0x11223344.
- Little endian: BIG_END=0, same memory and same request → rd_data=0x44332211; earlier rd_data is held unchanged until this rd_ok.
- Window miss: rd_addr=0x7000_0000 → rd_ok next cycle, rd_data=0, mem_rd never asserted.
- Overrun: second rd_req 5 cycles into a hit → ignored, first rd_data correct, overrun=1; ovr_clr and a new overrun event in the same cycle → overrun stays 1; ovr_clr alone → overrun=0 next cycle.
- Reset mid-transfer: drop rst_n during byte 2 → mem_rd=0 and busy=0 immediately; release, then read 0x6000_FFFC (last word, AW=16) → mem_addr 0xFFFC..0xFFFF, correct data.
- LAT=1 sweep: back-to-back requests, each issued the cycle after rd_ok → each rd_ok 9 cycles after its request, no overrun.
